// File: rtl/xnorpop_pkg.sv
// rtl/xnorpop_pkg.sv - shared types and helpers for the xnorpop accumulator slice
// Saturating adds return {overflow, sum[31:0]} so callers can slice to their own width.
package xnorpop_pkg;

  typedef enum logic {ST_FIRST, ST_RUN} state_t;

  function automatic int f_clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

  function automatic logic [32:0] sat_add_u(input logic [31:0] a, input logic [31:0] b,
                                            input int w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    if (s > mx) return {1'b1, mx[31:0]};
    return {1'b0, s[31:0]};
  endfunction

  function automatic logic [32:0] sat_add_s(input logic signed [31:0] a,
                                            input logic signed [31:0] b, input int w);
    logic signed [32:0] s;
    logic signed [32:0] mx;
    logic signed [32:0] mn;
    s  = {a[31], a} + {b[31], b};
    mx = (33'sd1 <<< (w - 1)) - 33'sd1;
    mn = -(33'sd1 <<< (w - 1));
    if (s > mx) return {1'b1, mx[31:0]};
    if (s < mn) return {1'b1, mn[31:0]};
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// rtl/popcount_tree.sv - combinational binary adder tree counting set bits
// Recursively halves the input so depth grows with log2(DATA_W).
module popcount_tree
  import xnorpop_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = f_clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  generate
    if (DATA_W == 1) begin : g_leaf
      assign count = CNT_W'(bits);
    end else begin : g_node
      localparam int LO_W = DATA_W / 2;
      localparam int HI_W = DATA_W - LO_W;
      localparam int LO_C = f_clog2(LO_W + 1);
      localparam int HI_C = f_clog2(HI_W + 1);
      logic [LO_C-1:0] lo_cnt;
      logic [HI_C-1:0] hi_cnt;

      popcount_tree #(.DATA_W(LO_W), .CNT_W(LO_C)) u_lo (
        .bits  (bits[LO_W-1:0]),
        .count (lo_cnt)
      );
      popcount_tree #(.DATA_W(HI_W), .CNT_W(HI_C)) u_hi (
        .bits  (bits[DATA_W-1:LO_W]),
        .count (hi_cnt)
      );

      assign count = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
    end
  endgenerate

endmodule

// File: rtl/xnorpop_accum.sv
// rtl/xnorpop_accum.sv - pipelined XNOR-popcount vector accumulator with valid/ready
// Define XNORPOP_BIPOLAR_EN for signed {-1,+1} dot products instead of unsigned popcounts.
module xnorpop_accum
  import xnorpop_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = f_clog2(DATA_W + 1);

  logic [CNT_W-1:0] pop_comb;
  logic [CNT_W-1:0] s1_pop;
  logic             s1_valid;
  logic             s1_last;
  logic             stall;
  logic             in_fire;
  logic             s1_take;
  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic             ovf, ovf_next;
  logic [ACC_W-1:0] base;
  logic             base_ovf;
  logic [32:0]      add_r;
  logic             unused_add;

  popcount_tree #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pop (
    .bits  (~(in_x ^ in_y)),
    .count (pop_comb)
  );

  // Only a finished vector waiting on a full output register can block the pipe.
  assign stall    = s1_valid && s1_last && out_valid && !out_ready;
  assign in_ready = !stall;
  assign in_fire  = in_valid && in_ready;
  assign s1_take  = s1_valid && !stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_pop   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      s1_pop   <= pop_comb;
    end else if (!stall) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef XNORPOP_BIPOLAR_EN
  logic signed [CNT_W:0] contrib;
  assign contrib = $signed({s1_pop, 1'b0} - (CNT_W + 1)'(DATA_W));
`endif

  always_comb begin
    state_next = state;
    acc_next   = acc;
    ovf_next   = ovf;
    // A new vector starts from zero with a clear overflow flag.
    base       = (state == ST_FIRST) ? '0 : acc;
    base_ovf   = (state == ST_RUN) && ovf;
`ifdef XNORPOP_BIPOLAR_EN
    add_r      = sat_add_s(32'($signed(base)), 32'(contrib), ACC_W);
`else
    add_r      = sat_add_u(32'(base), 32'(s1_pop), ACC_W);
`endif
    if (s1_take) begin
      acc_next   = add_r[ACC_W-1:0];
      ovf_next   = base_ovf | add_r[32];
      state_next = s1_last ? ST_FIRST : ST_RUN;
    end
  end

  assign unused_add = ^add_r[31:ACC_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FIRST;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      ovf   <= ovf_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (s1_take && s1_last) begin
      out_valid <= 1'b1;
      out_sum   <= acc_next;
      out_ovf   <= ovf_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xnorpop_accum.sv
// tb/tb_xnorpop_accum.sv - directed bench for xnorpop_accum (16-bit and 8-bit accumulators)
module tb_xnorpop_accum;

  localparam logic [127:0] ONES = '1;
  localparam logic [127:0] PAT1 = {32{4'h1}};
  localparam logic [127:0] KVAL = 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [127:0] in_x, in_y;
  logic [15:0]  out_sum;
  logic         v8, r8, l8, ov8, or8, ovf8;
  logic [127:0] x8, y8;
  logic [7:0]   s8;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  xnorpop_accum #(.DATA_W(128), .ACC_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  xnorpop_accum #(.DATA_W(128), .ACC_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(r8),
    .in_x(x8), .in_y(y8), .in_last(l8), .out_valid(ov8),
    .out_ready(or8), .out_sum(s8), .out_ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; x8 = '0; y8 = '0; l8 = 1'b0; or8 = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    chk("rst_ready", 32'(in_ready), 1);
    tick(); tick();
    reset_n = 1'b1;

    // single beat, every bit differs
    in_valid = 1'b1; in_x = '0; in_y = ONES; in_last = 1'b1;
    chk("t1_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("t1_lat_early", 32'(out_valid), 0);
    tick();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_sum", 32'(out_sum), 0);
    chk("t1_ovf", 32'(out_ovf), 0);
    tick();
    chk("t1_drain", 32'(out_valid), 0);

    // single beat, every bit matches
    in_valid = 1'b1; in_x = '0; in_y = '0; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_sum", 32'(out_sum), 128);
    tick();

    // three beats of 96 matching bits each
    in_valid = 1'b1; in_x = '0; in_y = PAT1; in_last = 1'b0;
    tick();
    tick();
    chk("t3_mid_valid", 32'(out_valid), 0);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t3_lat_early", 32'(out_valid), 0);
    tick();
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_sum", 32'(out_sum), 288);
    tick();
    chk("t3_drain", 32'(out_valid), 0);

    // backpressure with two single-beat vectors queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = KVAL; in_y = KVAL; in_last = 1'b1;
    tick();
    in_x = '0; in_y = ONES;
    chk("t4_ready_b", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("t4_stall", 32'(in_ready), 0);
    chk("t4_valid_a", 32'(out_valid), 1);
    chk("t4_sum_a", 32'(out_sum), 128);
    tick();
    chk("t4_stall_hold", 32'(in_ready), 0);
    chk("t4_sum_hold", 32'(out_sum), 128);
    out_ready = 1'b1;
    tick();
    chk("t4_valid_b", 32'(out_valid), 1);
    chk("t4_sum_b", 32'(out_sum), 0);
    tick();
    chk("t4_drain", 32'(out_valid), 0);
    chk("t4_ready_back", 32'(in_ready), 1);

    // saturation on the 8-bit accumulator, then a clean vector
    v8 = 1'b1; x8 = KVAL; y8 = KVAL; l8 = 1'b0;
    tick(); tick();
    l8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    chk("t5_valid", 32'(ov8), 1);
    chk("t5_sum_sat", 32'(s8), 255);
    chk("t5_ovf", 32'(ovf8), 1);
    v8 = 1'b1;
    tick();
    v8 = 1'b0; l8 = 1'b0;
    tick();
    chk("t5_sum_clean", 32'(s8), 128);
    chk("t5_ovf_clear", 32'(ovf8), 0);
    tick();

    // reset in the middle of a vector with a result still pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = KVAL; in_y = KVAL; in_last = 1'b1;
    tick();
    in_last = 1'b0;
    tick();
    chk("t6_pending", 32'(out_valid), 1);
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_sum", 32'(out_sum), 0);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_x = ONES; in_y = ONES; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_sum", 32'(out_sum), 128);
    chk("t6_ovf", 32'(out_ovf), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
